multicycle_tv_sequencer: RTL and testbench



---
 rtl/tv_seq_pkg.sv | 61 ++++++
 rtl/tv_seq_mem.sv | 33 +++
 rtl/multicycle_tv_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_tv_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tv_seq_pkg
// Brief    : Shared types, opcodes and instruction classifier for the
//            multicycle test-vector sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    typedef enum logic [2:0] {
        CLS_DP  = 3'd0,
        CLS_STR = 3'd1,
        CLS_LDR = 3'd2,
        CLS_B   = 3'd3,
        CLS_ILL = 3'd4
    } cls_e;

    localparam int C_DEF_CYC_B   = 3;
    localparam int C_DEF_CYC_DP  = 4;
    localparam int C_DEF_CYC_STR = 4;
    localparam int C_DEF_CYC_LDR = 5;

    function automatic cls_e classify(input logic [1:0] op, input logic l_bit);
        cls_e cls;
        case (op)
            OP_DP:   cls = CLS_DP;
            OP_MEM:  cls = l_bit ? CLS_LDR : CLS_STR;
            OP_B:    cls = CLS_B;
            default: cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    // Illegal opcodes take the data-processing length.
    function automatic logic [3:0] class_len(input cls_e cls,
                                             input logic [3:0] cyc_b,
                                             input logic [3:0] cyc_dp,
                                             input logic [3:0] cyc_str,
                                             input logic [3:0] cyc_ldr);
        logic [3:0] len;
        case (cls)
            CLS_B:   len = cyc_b;
            CLS_STR: len = cyc_str;
            CLS_LDR: len = cyc_ldr;
            default: len = cyc_dp;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tv_seq_mem.sv
`default_nettype none
// ============================================================================
// Module   : tv_seq_mem
// Brief    : Vector store, one synchronous write port and one combinational
//            read port. Contents survive reset.
// Revision : 1.0 - initial release
// ============================================================================
module tv_seq_mem #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 69,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Out-of-range reads (non power-of-two DEPTH) return an invalid slot.
    assign rdata = (int'(raddr) < DEPTH) ? r_mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/multicycle_tv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_tv_sequencer
// Brief    : Applies stored vectors to a multicycle ARM core for the number
//            of cycles its class needs and checks the result on the last one.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_tv_sequencer #(
    parameter int               INSTR_W  = 32,
    parameter int               FLAGS_W  = 4,
    parameter int               RES_W    = 32,
    parameter int               DEPTH    = 64,
    parameter int               ERR_W    = 16,
    parameter int               CYC_B    = 3,
    parameter int               CYC_DP   = 4,
    parameter int               CYC_STR  = 4,
    parameter int               CYC_LDR  = 5,
    parameter logic [RES_W-1:0] CMP_MASK = {RES_W{1'b1}},
    localparam int              ADDR_W   = $clog2(DEPTH),
    localparam int              VEC_W    = 1 + INSTR_W + FLAGS_W + RES_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [VEC_W-1:0]   load_data,
    input  logic               start,
    output logic [INSTR_W-1:0] instr,
    output logic [FLAGS_W-1:0] flags,
    output logic               step,
    input  logic [RES_W-1:0]   dut_result,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  vec_idx,
    output logic [ERR_W-1:0]   errors,
    output logic               err,
    output logic               first_err_valid,
    output logic [ADDR_W-1:0]  first_err_idx
);
    import tv_seq_pkg::*;

    state_e             r_state, w_state_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic [FLAGS_W-1:0] r_flags, w_flags_nxt;
    logic [RES_W-1:0]   r_exp, w_exp_nxt;
    logic               r_step, w_step_nxt;
    logic [ADDR_W-1:0]  r_vec_idx, w_vec_idx_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [ERR_W-1:0]   r_errors, w_errors_nxt;
    logic               r_err, w_err_nxt;
    logic               r_fev, w_fev_nxt;
    logic [ADDR_W-1:0]  r_fei, w_fei_nxt;

    logic [ADDR_W-1:0]  w_rd_addr;
    logic [VEC_W-1:0]   w_rd_data;
    logic               w_rd_valid;
    logic [INSTR_W-1:0] w_rd_instr;
    logic [FLAGS_W-1:0] w_rd_flags;
    logic [RES_W-1:0]   w_rd_exp;

    cls_e               w_cls;
    logic [3:0]         w_len;
    logic               w_check;
    logic               w_illegal;
    logic               w_mismatch;
    logic               w_fail;
    logic               w_last;
    logic [1:0]         w_inc;
    logic [ERR_W+1:0]   w_err_sum;
    logic [ERR_W-1:0]   w_errors_sat;

    tv_seq_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (VEC_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (load_en && (r_state != RUN)),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (w_rd_addr),
        .rdata (w_rd_data)
    );

    // Start reads slot 0; during a run the read port always looks one slot ahead.
    assign w_rd_addr  = (r_state == RUN) ? (r_vec_idx + ADDR_W'(1)) : '0;
    assign w_rd_valid = w_rd_data[VEC_W-1];
    assign w_rd_instr = w_rd_data[VEC_W-2 -: INSTR_W];
    assign w_rd_flags = w_rd_data[FLAGS_W+RES_W-1 -: FLAGS_W];
    assign w_rd_exp   = w_rd_data[RES_W-1:0];

    assign w_cls      = classify(r_instr[27:26], r_instr[20]);
    assign w_len      = class_len(w_cls, 4'(CYC_B), 4'(CYC_DP), 4'(CYC_STR), 4'(CYC_LDR));
    assign w_check    = (r_cnt == (w_len - 4'd1));
    assign w_illegal  = (w_cls == CLS_ILL);
    assign w_mismatch = |((dut_result ^ r_exp) & CMP_MASK);
    assign w_fail     = w_mismatch | w_illegal;
    assign w_last     = (r_vec_idx == ADDR_W'(DEPTH - 1)) || !w_rd_valid;

    assign w_inc        = {1'b0, w_mismatch} + {1'b0, w_illegal};
    assign w_err_sum    = {2'b00, r_errors} + {{ERR_W{1'b0}}, w_inc};
    assign w_errors_sat = (w_err_sum > {2'b00, {ERR_W{1'b1}}}) ? {ERR_W{1'b1}}
                                                              : w_err_sum[ERR_W-1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_instr_nxt   = r_instr;
        w_flags_nxt   = r_flags;
        w_exp_nxt     = r_exp;
        w_step_nxt    = 1'b0;
        w_vec_idx_nxt = r_vec_idx;
        w_cnt_nxt     = r_cnt;
        w_errors_nxt  = r_errors;
        w_err_nxt     = 1'b0;
        w_fev_nxt     = r_fev;
        w_fei_nxt     = r_fei;

        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_errors_nxt  = '0;
                    w_fev_nxt     = 1'b0;
                    w_fei_nxt     = '0;
                    w_vec_idx_nxt = '0;
                    if (w_rd_valid) begin
                        w_instr_nxt = w_rd_instr;
                        w_flags_nxt = w_rd_flags;
                        w_exp_nxt   = w_rd_exp;
                        w_cnt_nxt   = 4'd0;
                        w_step_nxt  = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (w_check) begin
                    w_errors_nxt = w_errors_sat;
                    if (w_fail) begin
                        w_err_nxt = 1'b1;
                        if (!r_fev) begin
                            w_fev_nxt = 1'b1;
                            w_fei_nxt = r_vec_idx;
                        end
                    end
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_instr_nxt   = w_rd_instr;
                        w_flags_nxt   = w_rd_flags;
                        w_exp_nxt     = w_rd_exp;
                        w_vec_idx_nxt = r_vec_idx + ADDR_W'(1);
                        w_cnt_nxt     = 4'd0;
                        w_step_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_instr   <= '0;
            r_flags   <= '0;
            r_exp     <= '0;
            r_step    <= 1'b0;
            r_vec_idx <= '0;
            r_cnt     <= 4'd0;
            r_errors  <= '0;
            r_err     <= 1'b0;
            r_fev     <= 1'b0;
            r_fei     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_instr   <= w_instr_nxt;
            r_flags   <= w_flags_nxt;
            r_exp     <= w_exp_nxt;
            r_step    <= w_step_nxt;
            r_vec_idx <= w_vec_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_errors  <= w_errors_nxt;
            r_err     <= w_err_nxt;
            r_fev     <= w_fev_nxt;
            r_fei     <= w_fei_nxt;
        end
    end

    assign instr           = r_instr;
    assign flags           = r_flags;
    assign step            = r_step;
    assign busy            = (r_state == RUN);
    assign done            = (r_state == DONE);
    assign vec_idx         = r_vec_idx;
    assign errors          = r_errors;
    assign err             = r_err;
    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fei;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_tv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_tv_sequencer
// Brief    : Randomised self-checking bench; two instances (full mask, and
//            low-byte mask with a 2-bit error counter) run in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_tv_sequencer;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int VEC_W  = 69;

    logic              clk = 1'b0;
    logic              reset, load_en, start;
    logic [ADDR_W-1:0] load_addr;
    logic [VEC_W-1:0]  load_data;
    logic [31:0]       dut_result;

    logic [31:0] a_instr, b_instr;
    logic [3:0]  a_flags, b_flags;
    logic        a_step, a_busy, a_done, a_err, a_fev;
    logic        b_step, b_busy, b_done, b_err, b_fev;
    logic [ADDR_W-1:0] a_vec_idx, a_fei, b_vec_idx, b_fei;
    logic [15:0] a_errors;
    logic [1:0]  b_errors;

    always #5 clk = ~clk;

    multicycle_tv_sequencer u_dut_a (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .instr(a_instr), .flags(a_flags),
        .step(a_step), .dut_result(dut_result), .busy(a_busy), .done(a_done),
        .vec_idx(a_vec_idx), .errors(a_errors), .err(a_err),
        .first_err_valid(a_fev), .first_err_idx(a_fei)
    );

    multicycle_tv_sequencer #(.ERR_W(2), .CMP_MASK(32'h0000_00FF)) u_dut_b (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .instr(b_instr), .flags(b_flags),
        .step(b_step), .dut_result(dut_result), .busy(b_busy), .done(b_done),
        .vec_idx(b_vec_idx), .errors(b_errors), .err(b_err),
        .first_err_valid(b_fev), .first_err_idx(b_fei)
    );

    // Reference store and run state.
    bit          m_valid [DEPTH];
    logic [31:0] m_instr [DEPTH];
    logic [3:0]  m_flags [DEPTH];
    logic [31:0] m_exp   [DEPTH];
    int          m_mode  [DEPTH];
    logic [31:0] cur_instr;
    logic [3:0]  cur_flags;
    int ea, eb, fia, fib;
    bit fva, fvb;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int vec_len(input logic [31:0] ins);
        case (ins[27:26])
            2'b00:   return 4;
            2'b01:   return ins[20] ? 5 : 4;
            2'b10:   return 3;
            default: return 4;
        endcase
    endfunction

    task automatic load_vec(input int a, input bit v, input logic [31:0] ins,
                            input logic [3:0] fl, input logic [31:0] ex);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = {v, ins, fl, ex};
        tick();
        load_en   = 1'b0;
        m_valid[a] = v; m_instr[a] = ins; m_flags[a] = fl; m_exp[a] = ex;
    endtask

    task automatic check_reset();
        check_val("rst_instr", a_instr, 0);   check_val("rst_flags", a_flags, 0);
        check_val("rst_step", a_step, 0);     check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);     check_val("rst_idx", a_vec_idx, 0);
        check_val("rst_errors", a_errors, 0); check_val("rst_err", a_err, 0);
        check_val("rst_fev", a_fev, 0);       check_val("rst_fei", a_fei, 0);
        check_val("rst_b_busy", b_busy, 0);   check_val("rst_b_errors", b_errors, 0);
        cur_instr = '0; cur_flags = '0;
    endtask

    // Runs one start..done pass; optionally asserts reset at (abort_vec, abort_cyc).
    task automatic run_seq(input int abort_vec, input int abort_cyc, output int cycles);
        int k, len, md;
        bit pa, pb, fa, fb, mia, mib, ill;
        logic [31:0] res;
        res = '0;
        start = 1'b1; tick(); start = 1'b0; cycles = 1;
        ea = 0; eb = 0; fva = 0; fvb = 0; fia = 0; fib = 0; pa = 0; pb = 0;
        if (!m_valid[0]) begin
            check_val("empty_done", a_done, 1); check_val("empty_busy", a_busy, 0);
            check_val("empty_errors", a_errors, 0); check_val("empty_step", a_step, 0);
            check_val("empty_instr", a_instr, cur_instr);
            return;
        end
        k = 0;
        forever begin
            len = vec_len(m_instr[k]);
            cur_instr = m_instr[k]; cur_flags = m_flags[k];
            for (int c = 0; c < len; c++) begin
                start = 1'b0; load_en = 1'b0;
                check_val("step", a_step, (c == 0));
                check_val("busy", a_busy, 1);
                check_val("vec_idx", a_vec_idx, k);
                check_val("instr", a_instr, cur_instr);
                check_val("flags", a_flags, cur_flags);
                check_val("err", a_err, (c == 0) ? pa : 1'b0);
                check_val("b_err", b_err, (c == 0) ? pb : 1'b0);
                check_val("b_step", b_step, (c == 0));
                if (k == abort_vec && c == abort_cyc) begin
                    reset = 1'b1; tick(); reset = 1'b0; cycles++;
                    return;
                end
                start     = ($urandom_range(0, 7) == 0);
                load_en   = ($urandom_range(0, 7) == 0);
                load_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                load_data = VEC_W'({$urandom(), $urandom(), $urandom()});
                if (c == len - 1) begin
                    md = (m_mode[k] == 3) ? $urandom_range(0, 3) : m_mode[k];
                    case (md)
                        0:       res = m_exp[k];
                        1:       res = m_exp[k] ^ 32'h0000_0001;
                        2:       res = m_exp[k] ^ 32'h8000_0000;
                        default: res = $urandom();
                    endcase
                end else begin
                    res = $urandom();
                end
                dut_result = res;
                tick(); cycles++;
            end
            start = 1'b0; load_en = 1'b0;
            mia = (res != m_exp[k]);
            mib = (((res ^ m_exp[k]) & 32'h0000_00FF) != 0);
            ill = (m_instr[k][27:26] == 2'b11);
            fa = mia | ill; fb = mib | ill;
            ea = ea + int'(mia) + int'(ill); if (ea > 65535) ea = 65535;
            eb = eb + int'(mib) + int'(ill); if (eb > 3) eb = 3;
            if (fa && !fva) begin fva = 1; fia = k; end
            if (fb && !fvb) begin fvb = 1; fib = k; end
            check_val("errors", a_errors, ea);
            check_val("b_errors", b_errors, eb);
            pa = fa; pb = fb;
            if (k == DEPTH - 1 || !m_valid[k + 1]) break;
            k++;
        end
        check_val("fin_done", a_done, 1);   check_val("fin_busy", a_busy, 0);
        check_val("fin_step", a_step, 0);   check_val("fin_idx", a_vec_idx, k);
        check_val("fin_err", a_err, pa);    check_val("fin_b_err", b_err, pb);
        check_val("fin_fev", a_fev, fva);   check_val("fin_fei", a_fei, fia);
        check_val("fin_b_fev", b_fev, fvb); check_val("fin_b_fei", b_fei, fib);
        check_val("fin_instr", a_instr, cur_instr);
        check_val("fin_b_done", b_done, 1);
        tick();
        check_val("done_hold", a_done, 1);  check_val("err_clear", a_err, 0);
    endtask

    task automatic clear_modes(input int md);
        for (int i = 0; i < DEPTH; i++) m_mode[i] = md;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; start = 1'b0;
        load_addr = '0; load_data = '0; dut_result = '0;
        clear_modes(0);
        tick(); tick();
        reset = 1'b0;
        check_reset();
        for (int i = 0; i < DEPTH; i++) load_vec(i, 0, 32'h0, 4'h0, 32'h0);

        // B, DP, STR, LDR then terminator: step at 1,4,8,12 and done at 17.
        load_vec(0, 1, 32'hEA00_0010, 4'h1, 32'h0000_1000);
        load_vec(1, 1, 32'hE081_0002, 4'h2, 32'h0000_0010);
        load_vec(2, 1, 32'hE580_1000, 4'h3, 32'h0000_2000);
        load_vec(3, 1, 32'hE590_1000, 4'h4, 32'hDEAD_BEEF);
        run_seq(-1, -1, cyc);
        check_val("basic_cycles", cyc, 17);
        check_val("basic_errors", a_errors, 0);

        // Mismatches on slots 1 and 3.
        m_mode[1] = 1; m_mode[3] = 1;
        run_seq(-1, -1, cyc);
        check_val("mm_errors", a_errors, 2);
        check_val("mm_fei", a_fei, 1);

        // Difference only in bit 31: masked instance must not count it.
        clear_modes(0); m_mode[0] = 2;
        run_seq(-1, -1, cyc);
        check_val("mask_a_errors", a_errors, 1);
        check_val("mask_b_errors", b_errors, 0);

        // Illegal opcode in slot 0.
        clear_modes(0);
        load_vec(0, 1, 32'hEC00_0000, 4'h5, 32'h1234_5678);
        load_vec(1, 0, 32'h0, 4'h0, 32'h0);
        run_seq(-1, -1, cyc);
        check_val("ill_cycles", cyc, 5);
        check_val("ill_errors", a_errors, 1);
        check_val("ill_fei", a_fei, 0);

        // Empty list.
        load_vec(0, 0, 32'h0, 4'h0, 32'h0);
        run_seq(-1, -1, cyc);
        check_val("empty_cycles", cyc, 1);

        // Every slot valid, random results.
        clear_modes(3);
        for (int i = 0; i < DEPTH; i++)
            load_vec(i, 1, $urandom(), 4'($urandom_range(0, 15)), $urandom());
        run_seq(-1, -1, cyc);
        check_val("full_idx", a_vec_idx, DEPTH - 1);

        // Reset during the 2nd cycle of an LDR, then an identical replay.
        clear_modes(0); m_mode[1] = 1;
        load_vec(0, 1, 32'hE590_2004, 4'h9, 32'h0000_00AA);
        load_vec(1, 1, 32'hE081_0003, 4'hA, 32'h0000_0055);
        load_vec(2, 0, 32'h0, 4'h0, 32'h0);
        run_seq(0, 1, cyc);
        check_reset();
        run_seq(-1, -1, cyc);
        check_val("replay_errors", a_errors, 1);
        check_val("replay_fei", a_fei, 1);

        // Random lists with random termination.
        clear_modes(3);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++)
                load_vec(i, (i == 0) || ($urandom_range(0, 15) != 0), $urandom(),
                         4'($urandom_range(0, 15)), $urandom());
            run_seq(-1, -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
